// File: rtl/or_64b.sv
// rtl/or_64b.sv - 64-bit bitwise OR with registered result and status flags
//
// Purpose:
//   Combinational s = a | b for same-cycle use by the ALU result mux.
//   Also a one-cycle registered copy with valid tracking plus zero, all-ones
//   and population-count flags.
//
// Ports:
//   clk       in   1      rising-edge clock for the registered stage
//   reset     in   1      synchronous, active-high reset
//   a, b      in   WIDTH  operands
//   in_valid  in   1      qualifies a/b for capture
//   s         out  WIDTH  combinational a | b
//   s_q       out  WIDTH  registered a | b
//   out_valid out  1      s_q and the flags were captured on the last edge
//   zero_q    out  1      registered (a | b) == 0
//   ones_q    out  1      registered (a | b) == all ones
//   popcnt_q  out  7      registered set-bit count of (a | b), 0..64
module or_64b #(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             in_valid,
  output logic [WIDTH-1:0] s,
  output logic [WIDTH-1:0] s_q,
  output logic             out_valid,
  output logic             zero_q,
  output logic             ones_q,
  output logic [6:0]       popcnt_q
);

  // Pure continuous assignment: no dependence on clk, reset or in_valid.
  assign s = a | b;

  logic       zero_d;
  logic       ones_d;
  logic [6:0] popcnt_d;

  assign zero_d = (s == '0);
  assign ones_d = (s == '1);

  // Population count as a balanced adder tree over the 64 result bits.
  // Each level pairs adjacent partial sums and widens them by one bit.
  logic [1:0] sum2 [32];
  logic [2:0] sum3 [16];
  logic [3:0] sum4 [8];
  logic [4:0] sum5 [4];
  logic [5:0] sum6 [2];

  always_comb begin
    for (int i = 0; i < 32; i++) begin
      sum2[i] = {1'b0, s[2*i]} + {1'b0, s[2*i+1]};
    end
    for (int i = 0; i < 16; i++) begin
      sum3[i] = {1'b0, sum2[2*i]} + {1'b0, sum2[2*i+1]};
    end
    for (int i = 0; i < 8; i++) begin
      sum4[i] = {1'b0, sum3[2*i]} + {1'b0, sum3[2*i+1]};
    end
    for (int i = 0; i < 4; i++) begin
      sum5[i] = {1'b0, sum4[2*i]} + {1'b0, sum4[2*i+1]};
    end
    for (int i = 0; i < 2; i++) begin
      sum6[i] = {1'b0, sum5[2*i]} + {1'b0, sum5[2*i+1]};
    end
    popcnt_d = {1'b0, sum6[0]} + {1'b0, sum6[1]};
  end

  // Without a new valid input the result and flags hold, but out_valid
  // drops so consumers see each captured result for exactly one cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      s_q       <= '0;
      out_valid <= 1'b0;
      zero_q    <= 1'b0;
      ones_q    <= 1'b0;
      popcnt_q  <= 7'd0;
    end else if (in_valid) begin
      s_q       <= s;
      out_valid <= 1'b1;
      zero_q    <= zero_d;
      ones_q    <= ones_d;
      popcnt_q  <= popcnt_d;
    end else begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_or_64b.sv
// tb/tb_or_64b.sv - self-checking random bench for or_64b
module tb_or_64b;

  logic        clk;
  logic        reset;
  logic [63:0] a;
  logic [63:0] b;
  logic        in_valid;
  logic [63:0] s;
  logic [63:0] s_q;
  logic        out_valid;
  logic        zero_q;
  logic        ones_q;
  logic [6:0]  popcnt_q;

  logic        clk_run;

  int n_checks;
  int n_errors;

  // Reference state for the registered stage.
  logic [63:0] m_sq;
  logic        m_valid;
  logic        m_zero;
  logic        m_ones;
  logic [6:0]  m_pop;

  or_64b #(.WIDTH(64)) dut (
    .clk      (clk),
    .reset    (reset),
    .a        (a),
    .b        (b),
    .in_valid (in_valid),
    .s        (s),
    .s_q      (s_q),
    .out_valid(out_valid),
    .zero_q   (zero_q),
    .ones_q   (ones_q),
    .popcnt_q (popcnt_q)
  );

  // Clock stays parked until the combinational phase is over.
  always #5 if (clk_run) clk = ~clk;

  initial begin
    #1ms;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] rand64();
    return {$urandom(), $urandom()};
  endfunction

  function automatic int bit_count(input logic [63:0] v);
    int c = 0;
    for (int i = 0; i < 64; i++) if (v[i]) c++;
    return c;
  endfunction

  // Drive one cycle of inputs, check s, take the edge, then check the
  // registered outputs against the reference.
  task automatic cycle(input logic [63:0] ta, input logic [63:0] tb, input logic tv, input logic tr);
    logic [63:0] o;
    a = ta; b = tb; in_valid = tv; reset = tr;
    o = ta | tb;
    #1;
    check("s_cyc", s, o);
    @(posedge clk);
    if (tr) begin
      m_sq = '0; m_valid = 1'b0; m_zero = 1'b0; m_ones = 1'b0; m_pop = 7'd0;
    end else if (tv) begin
      m_sq = o; m_valid = 1'b1;
      m_zero = (o == 64'd0);
      m_ones = (o == 64'hFFFF_FFFF_FFFF_FFFF);
      m_pop = 7'(bit_count(o));
    end else begin
      m_valid = 1'b0;
    end
    #1;
    check("s_q", s_q, m_sq);
    check("out_valid", {63'd0, out_valid}, {63'd0, m_valid});
    check("zero_q", {63'd0, zero_q}, {63'd0, m_zero});
    check("ones_q", {63'd0, ones_q}, {63'd0, m_ones});
    check("popcnt_q", {57'd0, popcnt_q}, {57'd0, m_pop});
    if (out_valid) check("flags_excl", {63'd0, zero_q & ones_q}, 64'd0);
  endtask

  logic [63:0] ca [4];
  logic [63:0] cb [4];
  logic [63:0] ce [4];

  initial begin
    n_checks = 0;
    n_errors = 0;
    clk = 1'b0;
    clk_run = 1'b0;
    reset = 1'b0;
    in_valid = 1'b0;
    a = '0;
    b = '0;

    // Combinational path with the clock stopped.
    for (int i = 0; i < 1000; i++) begin
      logic [63:0] ra, rb;
      ra = rand64(); rb = rand64();
      a = ra; b = rb;
      #10;
      check("s_rand", s, ra | rb);
    end

    ca[0] = 64'd0;                  cb[0] = 64'd0;                  ce[0] = 64'd0;
    ca[1] = 64'hFFFF_FFFF_FFFF_FFFF; cb[1] = 64'd0;                  ce[1] = 64'hFFFF_FFFF_FFFF_FFFF;
    ca[2] = 64'hAAAA_AAAA_AAAA_AAAA; cb[2] = 64'h5555_5555_5555_5555; ce[2] = 64'hFFFF_FFFF_FFFF_FFFF;
    ca[3] = 64'h8000_0000_0000_0001; cb[3] = 64'h8000_0000_0000_0001; ce[3] = 64'h8000_0000_0000_0001;
    for (int i = 0; i < 4; i++) begin
      a = ca[i]; b = cb[i];
      #10;
      check("s_corner", s, ce[i]);
    end

    // Reset wins over a valid all-ones input; s still shows all ones.
    clk_run = 1'b1;
    #1;
    cycle(64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1'b1, 1'b1);
    cycle(64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1'b1, 1'b1);

    // Single capture then hold.
    cycle(64'h0F, 64'hF0, 1'b1, 1'b0);
    cycle(64'h1234, 64'h0, 1'b0, 1'b0);
    check("hold_sq", s_q, 64'hFF);

    // Flag corners.
    cycle(64'd0, 64'd0, 1'b1, 1'b0);
    check("zero_flag", {63'd0, zero_q}, 64'd1);
    cycle(64'hFFFF_FFFF_0000_0000, 64'h0000_0000_FFFF_FFFF, 1'b1, 1'b0);
    check("pop64", {57'd0, popcnt_q}, 64'd64);

    // Back-to-back valid random pairs.
    for (int i = 0; i < 1000; i++) begin
      cycle(rand64(), rand64(), 1'b1, 1'b0);
    end

    // Mid-stream reset clears the registered outputs.
    cycle(rand64(), rand64(), 1'b1, 1'b1);
    cycle(rand64(), rand64(), 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
